// File: rtl/busca_instrucao.sv
// Instruction-fetch/sequencing unit: fetches the word at pc, holds it for
// execution and tells the PC block how to advance.
module busca_instrucao #(
    parameter int          LIMITE_ESPERA = 16,
    parameter logic [4:0]  OP_JUMP       = 5'b00010,
    parameter logic [4:0]  OP_JR         = 5'b00011,
    parameter logic [4:0]  OP_BEQ        = 5'b00100,
    parameter logic [4:0]  OP_HALT       = 5'b11111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        memPronto,
    input  logic [31:0] memDado,
    input  logic        flagZero,
    input  logic        stall,
    output logic        memReq,
    output logic [31:0] memEnd,
    output logic [2:0]  controlePC,
    output logic [31:0] instrucao,
    output logic        instrucaoValida,
    output logic [26:0] enderecoJump,
    output logic [16:0] deslocamentoBranch,
    output logic        erroBusca,
    output logic        parado
);

    localparam int CW = (LIMITE_ESPERA > 0) ? $clog2(LIMITE_ESPERA + 1) : 1;

    typedef enum logic [1:0] {INICIO, BUSCA, EXECUTA, PARADO} estado_t;

    estado_t       estado;
    logic [CW-1:0] espera;
    logic [4:0]    opcode;

    assign opcode = instrucao[31:27];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIO;
            instrucao <= '0;
            espera    <= '0;
            erroBusca <= 1'b0;
        end else begin
            case (estado)
                INICIO: estado <= BUSCA;
                BUSCA: begin
                    if (memPronto) begin
                        instrucao <= memDado;
                        espera    <= '0;
                        estado    <= EXECUTA;
                    end else begin
                        // Timeout fires on the cycle the count would reach the limit.
                        if (LIMITE_ESPERA != 0 && int'(espera) + 1 >= LIMITE_ESPERA) begin
                            erroBusca <= 1'b1;
                            estado    <= PARADO;
                        end
                        if (espera != '1)
                            espera <= espera + 1'b1;
                    end
                end
                EXECUTA: begin
                    if (!stall)
                        estado <= (opcode == OP_HALT) ? PARADO : BUSCA;
                end
                PARADO: estado <= PARADO;
                default: estado <= INICIO;
            endcase
        end
    end

    // Outputs decode from state and the held word; only controlePC sees stall/flagZero.
    always_comb begin
        memReq          = (estado == BUSCA);
        instrucaoValida = (estado == EXECUTA);
        parado          = (estado == PARADO);
        controlePC      = 3'b111;
        if (estado == EXECUTA && !stall) begin
            case (opcode)
                OP_JUMP: controlePC = 3'b001;
                OP_JR:   controlePC = 3'b011;
                OP_BEQ:  controlePC = flagZero ? 3'b010 : 3'b000;
                OP_HALT: controlePC = 3'b111;
                default: controlePC = 3'b000;
            endcase
        end
    end

    assign memEnd             = pc;
    assign enderecoJump       = instrucao[26:0];
    assign deslocamentoBranch = instrucao[16:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed plus randomized bench for busca_instrucao with a transaction-level model.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        memPronto = 1'b0;
    logic [31:0] memDado = '0;
    logic        flagZero = 1'b0;
    logic        stall = 1'b0;
    logic        memReq;
    logic [31:0] memEnd;
    logic [2:0]  controlePC;
    logic [31:0] instrucao;
    logic        instrucaoValida;
    logic [26:0] enderecoJump;
    logic [16:0] deslocamentoBranch;
    logic        erroBusca;
    logic        parado;

    int passed = 0;
    int total  = 0;
    logic [31:0] lastWord = '0;

    busca_instrucao #(.LIMITE_ESPERA(4)) dut (
        .clock(clock), .reset(reset), .pc(pc), .memPronto(memPronto),
        .memDado(memDado), .flagZero(flagZero), .stall(stall),
        .memReq(memReq), .memEnd(memEnd), .controlePC(controlePC),
        .instrucao(instrucao), .instrucaoValida(instrucaoValida),
        .enderecoJump(enderecoJump), .deslocamentoBranch(deslocamentoBranch),
        .erroBusca(erroBusca), .parado(parado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // PC-select each opcode should request once the instruction executes.
    function automatic logic [2:0] ctlEsperado(input logic [31:0] w, input logic fz);
        case (w[31:27])
            5'b00010: return 3'b001;
            5'b00011: return 3'b011;
            5'b00100: return fz ? 3'b010 : 3'b000;
            5'b11111: return 3'b111;
            default:  return 3'b000;
        endcase
    endfunction

    task automatic idleOutputs(input string tag, input logic expParado);
        chk({tag, ".memReq"}, {31'b0, memReq}, 32'd0);
        chk({tag, ".ctl"}, {29'b0, controlePC}, 32'd7);
        chk({tag, ".valid"}, {31'b0, instrucaoValida}, 32'd0);
        chk({tag, ".parado"}, {31'b0, parado}, {31'b0, expParado});
    endtask

    // Called at a negedge while the DUT is in BUSCA; returns at the negedge after EXECUTA.
    task automatic doFetch(input logic [31:0] w, input int lat, input int stalls, input logic fz);
        logic [2:0] ctl;
        for (int i = 0; i <= lat; i++) begin
            memPronto = (i == lat);
            memDado   = (i == lat) ? w : $urandom;
            #1;
            chk("busca.memReq", {31'b0, memReq}, 32'd1);
            chk("busca.memEnd", memEnd, pc);
            chk("busca.ctl", {29'b0, controlePC}, 32'd7);
            chk("busca.valid", {31'b0, instrucaoValida}, 32'd0);
            @(negedge clock);
        end
        memPronto = 1'b0;
        for (int i = 0; i <= stalls; i++) begin
            stall    = (i < stalls);
            flagZero = (i < stalls) ? 1'($urandom) : fz;
            #1;
            chk("exec.instr", instrucao, w);
            chk("exec.jump", {5'b0, enderecoJump}, {5'b0, w[26:0]});
            chk("exec.desl", {15'b0, deslocamentoBranch}, {15'b0, w[16:0]});
            chk("exec.valid", {31'b0, instrucaoValida}, 32'd1);
            chk("exec.memReq", {31'b0, memReq}, 32'd0);
            chk("exec.ctl", {29'b0, controlePC}, (i < stalls) ? 32'd7 : {29'b0, ctlEsperado(w, fz)});
            @(negedge clock);
        end
        stall = 1'b0;
        ctl = ctlEsperado(w, fz);
        if (ctl == 3'b001)      pc = {5'b0, w[26:0]};
        else if (ctl == 3'b000) pc = pc + 1;
        else if (ctl != 3'b111) pc = $urandom;
        lastWord = w;
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  ops [6];
        ops = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01010, 5'b00000};

        // Reset state
        #2;
        idleOutputs("reset", 1'b0);
        chk("reset.instr", instrucao, 32'd0);
        chk("reset.erro", {31'b0, erroBusca}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        idleOutputs("inicio", 1'b0);
        @(negedge clock);

        // Plain instruction, jump, branch taken/not taken, stalled execute
        doFetch(32'h0800_0005, 0, 0, 1'b0);
        doFetch(32'h1000_0040, 0, 0, 1'b0);
        chk("jump.pc", pc, 32'h40);
        doFetch(32'h2000_0010, 1, 0, 1'b1);
        doFetch(32'h2000_0010, 0, 0, 1'b0);
        doFetch(32'h0800_1234 | ($urandom & 32'h07FF_FFFF), 0, 3, 1'b0);

        for (int n = 0; n < 20; n++) begin
            w = $urandom;
            w[31:27] = ops[$urandom_range(5)];
            doFetch(w, $urandom_range(3), $urandom_range(2), 1'($urandom));
        end

        // Halt parks the unit
        doFetch(32'hF800_0000, 0, 1, 1'b0);
        #1;
        idleOutputs("halt", 1'b1);
        chk("halt.instr", instrucao, 32'hF800_0000);
        memPronto = 1'b1;
        @(negedge clock);
        #1;
        idleOutputs("halt.hold", 1'b1);
        chk("halt.erro", {31'b0, erroBusca}, 32'd0);
        memPronto = 1'b0;

        // Reset mid-fetch acts before the next clock edge
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("midreset.busca", {31'b0, memReq}, 32'd1);
        reset = 1'b0;
        #1;
        idleOutputs("midreset", 1'b0);
        chk("midreset.instr", instrucao, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Memory never answers: timeout after 4 waiting cycles
        pc = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wait.memReq", {31'b0, memReq}, 32'd1);
            chk("wait.erro", {31'b0, erroBusca}, 32'd0);
            @(negedge clock);
        end
        #1;
        idleOutputs("timeout", 1'b1);
        chk("timeout.erro", {31'b0, erroBusca}, 32'd1);
        memPronto = 1'b1;
        memDado   = 32'h0800_0001;
        repeat (2) @(negedge clock);
        #1;
        idleOutputs("timeout.hold", 1'b1);
        chk("timeout.erroHold", {31'b0, erroBusca}, 32'd1);
        chk("timeout.instr", instrucao, 32'd0);
        memPronto = 1'b0;
        reset = 1'b0;
        #1;
        chk("final.erro", {31'b0, erroBusca}, 32'd0);
        idleOutputs("final", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
